// File: rtl/rgb_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rgb_fade_ctrl
// Description : Three-channel PWM driver on one shared phase counter. Duty
//               updates only at frame boundaries, with optional 1-LSB ramping.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_fade_ctrl #(
    parameter int WIDTH  = 8,
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  target0,
    input  logic [WIDTH-1:0]  target1,
    input  logic [WIDTH-1:0]  target2,
    input  logic              fade_en,
    input  logic [RATE_W-1:0] rate,
    output logic              pwm0_out,
    output logic              pwm1_out,
    output logic              pwm2_out,
    output logic              busy,
    output logic              done
);

    localparam int               c_NCH        = 3;
    localparam logic [WIDTH-1:0] c_PHASE_LAST = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_phase;
    logic [WIDTH-1:0]    r_duty     [c_NCH];
    logic [WIDTH-1:0]    w_duty_nxt [c_NCH];
    logic [WIDTH-1:0]    r_tgt_q    [c_NCH];
    logic [WIDTH-1:0]    w_target   [c_NCH];
    logic [WIDTH-1:0]    w_tgt      [c_NCH];
    logic [RATE_W-1:0]   r_rate_q, w_rate;
    logic [RATE_W-1:0]   r_div, w_div_nxt;
    logic [c_NCH-1:0]    r_pwm;
    logic                r_done, w_done_nxt;
    logic                w_boundary;
    logic                w_any_diff;
    logic                w_all_eq;

    assign w_target[0] = target0;
    assign w_target[1] = target1;
    assign w_target[2] = target2;

    assign w_boundary = (r_phase == c_PHASE_LAST);

    // Targets and rate captured at this boundary govern this boundary's decisions.
    always_comb begin
        for (int i = 0; i < c_NCH; i++) begin
            w_tgt[i] = w_boundary ? w_target[i] : r_tgt_q[i];
        end
        w_rate = w_boundary ? rate : r_rate_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_rate_q <= '0;
            r_div    <= '0;
            r_pwm    <= '0;
            r_done   <= 1'b0;
            for (int i = 0; i < c_NCH; i++) begin
                r_duty[i]  <= '0;
                r_tgt_q[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_phase <= r_phase + 1'b1;
            r_div   <= w_div_nxt;
            r_done  <= w_done_nxt;
            for (int i = 0; i < c_NCH; i++) begin
                r_duty[i] <= w_duty_nxt[i];
                r_pwm[i]  <= (r_phase < r_duty[i]);
            end
            if (w_boundary) begin
                r_rate_q <= rate;
                for (int i = 0; i < c_NCH; i++) begin
                    r_tgt_q[i] <= w_target[i];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_done_nxt  = 1'b0;
        w_any_diff  = 1'b0;
        w_all_eq    = 1'b1;
        for (int i = 0; i < c_NCH; i++) begin
            w_duty_nxt[i] = r_duty[i];
            if (r_duty[i] != w_tgt[i]) begin
                w_any_diff = 1'b1;
            end
        end

        if (w_boundary) begin
            if (!fade_en) begin
                // Snap: also aborts any ramp without signalling completion.
                w_state_nxt = S_IDLE;
                w_div_nxt   = '0;
                for (int i = 0; i < c_NCH; i++) begin
                    w_duty_nxt[i] = w_tgt[i];
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_any_diff) begin
                            w_state_nxt = S_RAMP;
                            w_div_nxt   = '0;
                        end
                    end
                    S_RAMP: begin
                        if (r_div != w_rate) begin
                            w_div_nxt = r_div + 1'b1;
                        end else begin
                            w_div_nxt = '0;
                            for (int i = 0; i < c_NCH; i++) begin
                                if (r_duty[i] < w_tgt[i]) begin
                                    w_duty_nxt[i] = r_duty[i] + 1'b1;
                                end else if (r_duty[i] > w_tgt[i]) begin
                                    w_duty_nxt[i] = r_duty[i] - 1'b1;
                                end
                                if (w_duty_nxt[i] != w_tgt[i]) begin
                                    w_all_eq = 1'b0;
                                end
                            end
                            if (w_all_eq) begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign pwm0_out = r_pwm[0];
    assign pwm1_out = r_pwm[1];
    assign pwm2_out = r_pwm[2];
    assign busy     = (r_state == S_RAMP);
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_fade_ctrl
// Description : Frame-level scoreboard bench for rgb_fade_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_fade_ctrl;

    localparam int c_FRAME = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] target0 = '0, target1 = '0, target2 = '0;
    logic       fade_en = 1'b0;
    logic [3:0] rate = '0;
    logic       pwm0_out, pwm1_out, pwm2_out, busy, done;

    int checks = 0;
    int errors = 0;

    // Expected high-count per channel equals the frame's duty.
    typedef struct {
        int   d0;
        int   d1;
        int   d2;
        logic b;
        int   dn;
    } exp_t;

    exp_t q[$];

    rgb_fade_ctrl #(.WIDTH(8), .RATE_W(4)) dut (
        .clk      (clk),
        .reset    (rst),
        .target0  (target0),
        .target1  (target1),
        .target2  (target2),
        .fade_en  (fade_en),
        .rate     (rate),
        .pwm0_out (pwm0_out),
        .pwm1_out (pwm1_out),
        .pwm2_out (pwm2_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Monitor: frame m's pwm window is the samples after edges 256m+1..256m+256;
    // busy/done belong to the frame whose boundary edge produced them.
    initial begin : monitor
        int   k, c0, c1, c2, dacc, fidx;
        logic bs;
        exp_t e;
        k = 0; c0 = 0; c1 = 0; c2 = 0; dacc = 0; fidx = 0; bs = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                k = 0; c0 = 0; c1 = 0; c2 = 0; fidx = 0;
                bs   = busy;
                dacc = done ? 1 : 0;
                q.delete();
            end else begin
                k++;
                if (pwm0_out) c0++;
                if (pwm1_out) c1++;
                if (pwm2_out) c2++;
                if ((k % c_FRAME) != 0 && done) dacc++;
                if ((k % c_FRAME) == 0) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        checks++;
                        if (c0 != e.d0 || c1 != e.d1 || c2 != e.d2 || bs != e.b || dacc != e.dn) begin
                            errors++;
                            $display("FAIL frame%0d: got pwm=%0d/%0d/%0d busy=%0b done=%0d, exp pwm=%0d/%0d/%0d busy=%0b done=%0d",
                                     fidx, c0, c1, c2, bs, dacc, e.d0, e.d1, e.d2, e.b, e.dn);
                        end
                    end
                    fidx++;
                    c0 = 0; c1 = 0; c2 = 0;
                    bs   = busy;
                    dacc = done ? 1 : 0;
                end
            end
        end
    end

    task automatic chk_zero(input string name);
        checks++;
        if ({pwm0_out, pwm1_out, pwm2_out, busy, done} != 5'b0) begin
            errors++;
            $display("FAIL %s: got pwm=%b%b%b busy=%b done=%b, exp all 0",
                     name, pwm0_out, pwm1_out, pwm2_out, busy, done);
        end
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset_outputs");
        #1;
        q.push_back('{0, 0, 0, 1'b0, 0});
        rst = 1'b0;
    endtask

    // Inputs applied here are sampled at the next boundary; exp is that frame.
    task automatic frm(input int t0, input int t1, input int t2, input logic fe, input int rt,
                       input int e0, input int e1, input int e2, input logic eb, input int ed);
        target0 = 8'(t0);
        target1 = 8'(t1);
        target2 = 8'(t2);
        fade_en = fe;
        rate    = 4'(rt);
        q.push_back('{e0, e1, e2, eb, ed});
        repeat (c_FRAME) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        release_reset();
        // Idle after reset: all low for four frames
        repeat (3) frm(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
        // Snap
        frm(64, 0, 0, 0, 0,  64, 0, 0, 0, 0);
        frm(64, 0, 0, 0, 0,  64, 0, 0, 0, 0);
        frm(0,  0, 0, 0, 0,   0, 0, 0, 0, 0);
        // Ramp 0 -> 3 at rate 0
        frm(3, 0, 0, 1, 0,  0, 0, 0, 1, 0);
        frm(3, 0, 0, 1, 0,  1, 0, 0, 1, 0);
        frm(3, 0, 0, 1, 0,  2, 0, 0, 1, 0);
        frm(3, 0, 0, 1, 0,  3, 0, 0, 0, 1);
        frm(3, 0, 0, 1, 0,  3, 0, 0, 0, 0);
        // Rate 2: step every third boundary
        frm(3, 2, 0, 1, 2,  3, 0, 0, 1, 0);
        frm(3, 2, 0, 1, 2,  3, 0, 0, 1, 0);
        frm(3, 2, 0, 1, 2,  3, 0, 0, 1, 0);
        frm(3, 2, 0, 1, 2,  3, 1, 0, 1, 0);
        frm(3, 2, 0, 1, 2,  3, 1, 0, 1, 0);
        frm(3, 2, 0, 1, 2,  3, 1, 0, 1, 0);
        frm(3, 2, 0, 1, 2,  3, 2, 0, 0, 1);
        frm(3, 2, 0, 1, 2,  3, 2, 0, 0, 0);
        // Retarget 10 -> 4 while duty is 6
        frm(10, 2, 0, 1, 0,  3, 2, 0, 1, 0);
        frm(10, 2, 0, 1, 0,  4, 2, 0, 1, 0);
        frm(10, 2, 0, 1, 0,  5, 2, 0, 1, 0);
        frm(10, 2, 0, 1, 0,  6, 2, 0, 1, 0);
        frm(4,  2, 0, 1, 0,  5, 2, 0, 1, 0);
        frm(4,  2, 0, 1, 0,  4, 2, 0, 0, 1);
        frm(4,  2, 0, 1, 0,  4, 2, 0, 0, 0);
        // Drop fade_en mid-ramp: snap, no done
        frm(20, 2, 0, 1, 0,  4, 2, 0, 1, 0);
        frm(20, 2, 0, 1, 0,  5, 2, 0, 1, 0);
        frm(20, 2, 0, 1, 0,  6, 2, 0, 1, 0);
        frm(20, 2, 0, 0, 0,  20, 2, 0, 0, 0);
        frm(20, 2, 0, 0, 0,  20, 2, 0, 0, 0);
        // Reset mid-ramp: outputs clear immediately
        frm(0, 2, 0, 1, 3,  20, 2, 0, 1, 0);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_reset_midramp");
        target0 = '0; target1 = '0; target2 = '0; fade_en = 1'b0; rate = '0;
        release_reset();
        // Full-scale opposing ramps, channel 2 held
        frm(0,   255, 128, 0, 0,  0, 255, 128, 0, 0);
        frm(255, 0,   128, 1, 0,  0, 255, 128, 1, 0);
        for (int j = 1; j <= 255; j++) begin
            frm(255, 0, 128, 1, 0,  j, 255 - j, 128, (j < 255), (j == 255) ? 1 : 0);
        end
        frm(255, 0, 128, 1, 0,  255, 0, 128, 0, 0);
        repeat (c_FRAME + 40) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1500000;
        errors++;
        $display("FAIL timeout: got no completion, exp finish before 1500000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
